// File: rtl/ber_pkg.sv
// Shared types and helpers for the PRBS BER checker and the matching TX PRBS generator.
// No logic of its own; everything here is constants, types and a pure function.
// Backpressure: not applicable.
package ber_pkg;

   // Default PRBS7 polynomial x^7 + x^6 + 1
   localparam int DEF_PRBS_LEN = 7;
   localparam int DEF_PRBS_TAP = 6;

   // Widest LFSR the shared shift helper supports (LEN must stay below this)
   localparam int PRBS_MAX_LEN = 32;

   typedef enum logic [1:0] {
      SEED   = 2'b00,
      VERIFY = 2'b01,
      LOCKED = 2'b10
   } ber_state_t;

   // One left shift of the LFSR with bit_in entering at the LSB
   function automatic logic [PRBS_MAX_LEN-1:0] prbs_next(input logic [PRBS_MAX_LEN-1:0] lfsr,
                                                         input logic                    bit_in);
      return (lfsr << 1) | PRBS_MAX_LEN'(bit_in);
   endfunction

endpackage

// File: rtl/prbs_ber_checker_if.sv
// Recovered bit stream from the gray decoder into the BER checker.
// Carries at most one bit per cycle, qualified by data_in_valid.
// No backpressure: the consumer must take every valid bit.
interface prbs_ber_checker_if;
   logic data_in;
   logic data_in_valid;

   modport master (output data_in, output data_in_valid);
   modport slave  (input  data_in, input  data_in_valid);
endinterface

// File: rtl/prbs_lfsr.sv
// Fibonacci PRBS LFSR x^LEN + x^TAP + 1 with a load-bit / free-run select; shared with TX.
// pred is combinational from the register; the register updates on the edge after advance.
// Holds its state whenever advance is low.
module prbs_lfsr
   import ber_pkg::*;
#(
   parameter int LEN = DEF_PRBS_LEN,
   parameter int TAP = DEF_PRBS_TAP
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           advance,
   input  logic           load_sel,
   input  logic           bit_in,
   output logic           pred,
   output logic [LEN-1:0] lfsr
);

   logic                    shift_bit;
   logic [PRBS_MAX_LEN-1:0] next_wide;
   logic                    unused_hi;

   assign pred      = lfsr[LEN-1] ^ lfsr[TAP-1];
   // load_sel=1 trains the register from the line, load_sel=0 lets it run on its own prediction
   assign shift_bit = load_sel ? bit_in : pred;
   assign next_wide = prbs_next(PRBS_MAX_LEN'(lfsr), shift_bit);
   assign unused_hi = ^next_wide[PRBS_MAX_LEN-1:LEN];

   // Shift register: advance one position per accepted bit
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         lfsr <= '0;
      end else if (advance) begin
         lfsr <= next_wide[LEN-1:0];
      end
   end

endmodule

// File: rtl/prbs_ber_checker.sv
// PRBS self-synchronising BER checker: seed, verify, then count bits/errors while locked.
// All outputs registered: counters, err_pulse and locked follow an accepted bit by one cycle.
// No backpressure; bits are accepted only when en and data_in_valid are both high.
module prbs_ber_checker
   import ber_pkg::*;
#(
   parameter int PRBS_LEN    = DEF_PRBS_LEN,
   parameter int PRBS_TAP    = DEF_PRBS_TAP,
   parameter int CNT_W       = 48,
   parameter int LOCK_THRESH = 64,
   parameter int WIN_LEN     = 256,
   parameter int UNLOCK_ERRS = 32
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 en,
   prbs_ber_checker_if.slave    rx,
   input  logic                 clear_counts,
   output logic                 locked,
   output logic [CNT_W-1:0]     bit_count,
   output logic [CNT_W-1:0]     err_count,
   output logic                 err_pulse,
   output logic                 sat,
   output logic [1:0]           state_dbg
);

   localparam int SEED_W  = $clog2(PRBS_LEN + 1);
   localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
   localparam int WBITS_W = $clog2(WIN_LEN + 1);
   localparam int WERR_W  = $clog2(UNLOCK_ERRS + 1);

   ber_state_t          state;
   ber_state_t          state_next;
   logic [SEED_W-1:0]   seed_cnt;
   logic [MATCH_W-1:0]  match_cnt;
   logic [WBITS_W-1:0]  win_bits;
   logic [WERR_W-1:0]   win_err;

   logic                accept;
   logic                pred;
   logic                mismatch;
   logic [PRBS_LEN-1:0] lfsr;
   logic                seed_done;
   logic                lfsr_zero;
   logic                match_done;
   logic [WBITS_W-1:0]  win_bits_inc;
   logic [WERR_W-1:0]   win_err_inc;
   logic                win_done;
   logic                unlock_hit;
   logic                count_en;

   assign accept   = en & rx.data_in_valid;
   assign mismatch = rx.data_in ^ pred;

   prbs_lfsr #(
      .LEN (PRBS_LEN),
      .TAP (PRBS_TAP)
   ) u_lfsr (
      .clock    (clock),
      .reset_n  (reset_n),
      .advance  (accept),
      .load_sel (state != LOCKED),
      .bit_in   (rx.data_in),
      .pred     (pred),
      .lfsr     (lfsr)
   );

   assign seed_done    = (seed_cnt == SEED_W'(PRBS_LEN - 1));
   assign lfsr_zero    = (lfsr == '0);
   assign match_done   = !mismatch && (match_cnt == MATCH_W'(LOCK_THRESH - 1));
   assign win_bits_inc = win_bits + WBITS_W'(1);
   assign win_err_inc  = win_err + WERR_W'(mismatch);
   assign win_done     = (win_bits_inc == WBITS_W'(WIN_LEN));
   // Covers both the mid-window trip and the end-of-window evaluation
   assign unlock_hit   = (win_err_inc >= WERR_W'(UNLOCK_ERRS));

   // FSM state register
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= SEED;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state: only accepted bits move it, except recovery from the unused encoding
   always_comb begin
      state_next = state;
      case (state)
         SEED: begin
            if (accept && seed_done) state_next = VERIFY;
         end
         VERIFY: begin
            if (accept) begin
               if (lfsr_zero)       state_next = SEED;
               else if (match_done) state_next = LOCKED;
            end
         end
         LOCKED: begin
            if (accept && unlock_hit) state_next = SEED;
         end
         default: state_next = SEED;
      endcase
   end

   // FSM outputs decoded straight from the state register
   always_comb begin
      locked    = (state == LOCKED);
      state_dbg = state;
   end

   // Seed, match and window bookkeeping for the lock state machine
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         seed_cnt  <= '0;
         match_cnt <= '0;
         win_bits  <= '0;
         win_err   <= '0;
      end else if (accept) begin
         case (state)
            SEED: begin
               seed_cnt  <= seed_done ? '0 : seed_cnt + SEED_W'(1);
               match_cnt <= '0;
            end
            VERIFY: begin
               if (lfsr_zero) begin
                  seed_cnt  <= '0;
                  match_cnt <= '0;
               end else if (match_done) begin
                  match_cnt <= '0;
                  win_bits  <= '0;
                  win_err   <= '0;
               end else if (mismatch) begin
                  match_cnt <= '0;
               end else begin
                  match_cnt <= match_cnt + MATCH_W'(1);
               end
            end
            LOCKED: begin
               if (unlock_hit) begin
                  seed_cnt <= '0;
                  win_bits <= '0;
                  win_err  <= '0;
               end else if (win_done) begin
                  win_bits <= '0;
                  win_err  <= '0;
               end else begin
                  win_bits <= win_bits_inc;
                  win_err  <= win_err_inc;
               end
            end
            default: begin
               seed_cnt  <= '0;
               match_cnt <= '0;
            end
         endcase
      end
   end

   // Bits only count while locked and unsaturated; freezing both together keeps the ratio exact
   assign count_en = accept && (state == LOCKED) && !sat;

   // Reported counters, saturation flag and error pulse; clear_counts overrides a same-cycle bit
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         bit_count <= '0;
         err_count <= '0;
         sat       <= 1'b0;
         err_pulse <= 1'b0;
      end else if (clear_counts) begin
         bit_count <= '0;
         err_count <= '0;
         sat       <= 1'b0;
         err_pulse <= 1'b0;
      end else begin
         err_pulse <= count_en && mismatch;
         if (count_en) begin
            bit_count <= bit_count + CNT_W'(1);
            if (mismatch) err_count <= err_count + CNT_W'(1);
            if (bit_count == {{(CNT_W-1){1'b1}}, 1'b0}) sat <= 1'b1;
         end
      end
   end

endmodule
